// File: rtl/mem_wb_skid_reg_pkg.sv
// Shared definitions for the MEM/WB boundary: default widths and writeback-select encoding.
package mem_wb_skid_reg_pkg;

   localparam int DEF_DATA_W = 64;
   localparam int DEF_REG_AW = 5;

   // Encoding of the writeback mux select, shared with the decoder.
   localparam logic WB_SEL_ALU = 1'b0;
   localparam logic WB_SEL_MEM = 1'b1;

   function automatic int payload_w(input int data_w, input int reg_aw);
      return 2 * data_w + reg_aw + 2;
   endfunction

endpackage

// File: rtl/mem_wb_skid_reg_payload.sv
// Width-parameterised enable register with synchronous clear, holds one MEM/WB payload.
module wb_payload_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register built as a two-entry skid buffer (main + skid).
// in_ready comes straight from the skid valid flop, so out_ready never reaches it.
module mem_wb_skid_reg
   import mem_wb_skid_reg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REG_AW = DEF_REG_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_mem_data,
   input  logic              in_mem_to_reg,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_reg_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_alu_result,
   output logic [DATA_W-1:0] out_mem_data,
   output logic              out_sel,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_reg_we,
   output logic [1:0]        out_count
);

   localparam int PW = payload_w(DATA_W, REG_AW);

   logic          main_valid;
   logic          skid_valid;
   logic [PW-1:0] in_pl;
   logic [PW-1:0] main_d;
   logic [PW-1:0] main_q;
   logic [PW-1:0] skid_q;
   logic          clr;
   logic          accept;
   logic          emit;
   logic          main_en;
   logic          skid_en;
   logic          main_we;

   assign clr    = reset | flush;
   // A flushed cycle drops the offered entry even when the handshake completes.
   assign accept = in_valid & in_ready & ~flush;
   assign emit   = main_valid & out_ready;
   assign in_pl  = {in_alu_result, in_mem_data, in_mem_to_reg, in_rd, in_reg_we};

   // Main refills from skid first to keep FIFO order, else from the input.
   assign main_d  = skid_valid ? skid_q : in_pl;
   assign main_en = (~main_valid & accept) | (emit & (skid_valid | accept));
   assign skid_en = main_valid & ~emit & accept;

   always_ff @(posedge clk) begin
      if (clr) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         if (main_en)
            main_valid <= 1'b1;
         else if (emit)
            main_valid <= 1'b0;
         if (skid_en)
            skid_valid <= 1'b1;
         else if (emit)
            skid_valid <= 1'b0;
      end
   end

   wb_payload_reg #(.W(PW)) u_main (
      .clk (clk),
      .clr (clr),
      .en  (main_en),
      .d   (main_d),
      .q   (main_q)
   );

   wb_payload_reg #(.W(PW)) u_skid (
      .clk (clk),
      .clr (clr),
      .en  (skid_en),
      .d   (in_pl),
      .q   (skid_q)
   );

   assign {out_alu_result, out_mem_data, out_sel, out_rd, main_we} = main_q;

   assign in_ready   = ~skid_valid;
   assign out_valid  = main_valid;
   assign out_reg_we = emit & main_we & ~flush;
   assign out_count  = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Directed vector table plus streaming and randomised scoreboard runs for mem_wb_skid_reg.
module tb_mem_wb_skid_reg;
   import mem_wb_skid_reg_pkg::*;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_ready, in_mem_to_reg, in_reg_we;
   logic [63:0] in_alu_result, in_mem_data;
   logic [4:0]  in_rd;
   logic        out_valid, out_ready, out_sel, out_reg_we;
   logic [63:0] out_alu_result, out_mem_data;
   logic [4:0]  out_rd;
   logic [1:0]  out_count;

   int nvec = 0;
   int nmis = 0;

   always #5 clk = ~clk;

   mem_wb_skid_reg dut (
      .clk            (clk),
      .reset          (reset),
      .flush          (flush),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_alu_result  (in_alu_result),
      .in_mem_data    (in_mem_data),
      .in_mem_to_reg  (in_mem_to_reg),
      .in_rd          (in_rd),
      .in_reg_we      (in_reg_we),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_alu_result (out_alu_result),
      .out_mem_data   (out_mem_data),
      .out_sel        (out_sel),
      .out_rd         (out_rd),
      .out_reg_we     (out_reg_we),
      .out_count      (out_count)
   );

   typedef struct {
      logic        rst, fl, iv, ordy, we;
      logic [63:0] alu;
      logic        ev;
      logic [1:0]  ec;
      logic        er;
      logic [63:0] ealu;
      logic        chk_we, ewe;
   } vec_t;

   typedef struct {
      logic [63:0] alu, mem;
      logic        sel;
      logic [4:0]  rd;
      logic        we;
   } ent_t;

   vec_t tbl[17];
   ent_t sb[$];

   function automatic vec_t mk(logic rst, logic fl, logic iv, logic ordy, logic we,
                               logic [63:0] alu, logic ev, logic [1:0] ec, logic er,
                               logic [63:0] ealu, logic chk_we, logic ewe);
      vec_t v;
      v.rst = rst; v.fl = fl; v.iv = iv; v.ordy = ordy; v.we = we; v.alu = alu;
      v.ev = ev; v.ec = ec; v.er = er; v.ealu = ealu; v.chk_we = chk_we; v.ewe = ewe;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic fl, input logic iv, input logic ordy,
                        input ent_t e);
      reset         = rst;
      flush         = fl;
      in_valid      = iv;
      out_ready     = ordy;
      in_alu_result = e.alu;
      in_mem_data   = e.mem;
      in_mem_to_reg = e.sel;
      in_rd         = e.rd;
      in_reg_we     = e.we;
   endtask

   initial begin
      ent_t e;
      int   n;
      logic iv, ordy, exp_rdy, emit;

      e = '{alu: '0, mem: '0, sel: 1'b0, rd: '0, we: 1'b0};
      drive(1'b0, 1'b0, 1'b0, 1'b0, e);

      //            rst fl iv or we alu      ev ec er ealu   cw ewe
      tbl[0]  = mk(1, 0, 0, 0, 0, 64'h0,  0, 0, 1, 64'h0,  0, 0);
      tbl[1]  = mk(0, 0, 0, 1, 0, 64'h0,  0, 0, 1, 64'h0,  1, 0);
      tbl[2]  = mk(0, 0, 1, 0, 1, 64'h11, 1, 1, 1, 64'h11, 1, 0);
      tbl[3]  = mk(0, 0, 1, 0, 0, 64'h22, 1, 2, 0, 64'h11, 1, 0);
      tbl[4]  = mk(0, 0, 1, 0, 1, 64'h33, 1, 2, 0, 64'h11, 1, 0);
      tbl[5]  = mk(0, 0, 0, 1, 0, 64'h0,  1, 1, 1, 64'h22, 1, 1);
      tbl[6]  = mk(0, 0, 1, 1, 1, 64'h44, 1, 1, 1, 64'h44, 1, 0);
      tbl[7]  = mk(0, 0, 0, 1, 0, 64'h0,  0, 0, 1, 64'h0,  1, 1);
      tbl[8]  = mk(0, 0, 1, 0, 1, 64'h55, 1, 1, 1, 64'h55, 1, 0);
      tbl[9]  = mk(0, 0, 1, 0, 1, 64'h66, 1, 2, 0, 64'h55, 1, 0);
      tbl[10] = mk(0, 1, 1, 1, 1, 64'h77, 0, 0, 1, 64'h0,  1, 0);
      tbl[11] = mk(0, 0, 0, 1, 0, 64'h0,  0, 0, 1, 64'h0,  1, 0);
      tbl[12] = mk(0, 0, 1, 0, 1, 64'h88, 1, 1, 1, 64'h88, 1, 0);
      tbl[13] = mk(0, 0, 1, 0, 1, 64'h99, 1, 2, 0, 64'h88, 1, 0);
      tbl[14] = mk(1, 0, 1, 1, 1, 64'hAA, 0, 0, 1, 64'h0,  0, 0);
      tbl[15] = mk(0, 0, 1, 1, 1, 64'hBB, 1, 1, 1, 64'hBB, 1, 0);
      tbl[16] = mk(0, 0, 0, 1, 0, 64'h0,  0, 0, 1, 64'h0,  1, 1);

      for (int i = 0; i < 17; i++) begin
         @(negedge clk);
         e.alu = tbl[i].alu;
         e.mem = ~tbl[i].alu;
         e.sel = tbl[i].alu[0];
         e.rd  = tbl[i].alu[4:0];
         e.we  = tbl[i].we;
         drive(tbl[i].rst, tbl[i].fl, tbl[i].iv, tbl[i].ordy, e);
         #1;
         if (tbl[i].chk_we) chk($sformatf("tbl%0d reg_we", i), 64'(out_reg_we), 64'(tbl[i].ewe));
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d valid", i), 64'(out_valid), 64'(tbl[i].ev));
         chk($sformatf("tbl%0d count", i), 64'(out_count), 64'(tbl[i].ec));
         chk($sformatf("tbl%0d in_ready", i), 64'(in_ready), 64'(tbl[i].er));
         if (tbl[i].ev) begin
            chk($sformatf("tbl%0d alu", i), out_alu_result, tbl[i].ealu);
            chk($sformatf("tbl%0d mem", i), out_mem_data, ~tbl[i].ealu);
            chk($sformatf("tbl%0d sel", i), 64'(out_sel), 64'(tbl[i].ealu[0]));
            chk($sformatf("tbl%0d rd", i), 64'(out_rd), 64'(tbl[i].ealu[4:0]));
         end else if (tbl[i].rst || tbl[i].fl) begin
            chk($sformatf("tbl%0d zero", i),
                64'(out_alu_result | out_mem_data | 64'(out_sel) | 64'(out_rd)), 64'h0);
         end
      end

      // Back-to-back stream with out_ready held high: one entry per cycle, no bubbles.
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         e.alu = 64'(i);
         e.mem = 64'hFFFF_0000_0000_0000 + 64'(i);
         e.sel = (i % 2 == 1) ? WB_SEL_MEM : WB_SEL_ALU;
         e.rd  = 5'(i);
         e.we  = 1'b1;
         drive(1'b0, 1'b0, (i < 8), 1'b1, e);
         #1;
         if (i > 0) chk($sformatf("stream%0d reg_we", i - 1), 64'(out_reg_we), 64'h1);
         @(posedge clk);
         #1;
         if (i < 8) begin
            chk($sformatf("stream%0d valid", i), 64'(out_valid), 64'h1);
            chk($sformatf("stream%0d alu", i), out_alu_result, 64'(i));
            chk($sformatf("stream%0d mem", i), out_mem_data, 64'hFFFF_0000_0000_0000 + 64'(i));
            chk($sformatf("stream%0d sel", i), 64'(out_sel), 64'(i % 2));
            chk($sformatf("stream%0d rd", i), 64'(out_rd), 64'(i));
         end else begin
            chk("stream drained", 64'(out_valid), 64'h0);
         end
      end

      // Random valid/ready against a FIFO scoreboard of depth two.
      n = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         iv   = ($urandom_range(0, 99) < 60);
         ordy = ($urandom_range(0, 99) < 55);
         e.alu = 64'hA000_0000_0000_0000 + 64'(n);
         e.mem = 64'(n) * 64'd3;
         e.sel = n[0];
         e.rd  = n[4:0];
         e.we  = $urandom_range(0, 1) == 1;
         drive(1'b0, 1'b0, iv, ordy, e);
         #1;
         exp_rdy = (sb.size() < 2);
         emit    = (sb.size() > 0) && ordy;
         chk("rnd in_ready", 64'(in_ready), 64'(exp_rdy));
         chk("rnd valid", 64'(out_valid), 64'(sb.size() > 0));
         if (emit) begin
            chk("rnd alu", out_alu_result, sb[0].alu);
            chk("rnd mem", out_mem_data, sb[0].mem);
            chk("rnd sel", 64'(out_sel), 64'(sb[0].sel));
            chk("rnd rd", 64'(out_rd), 64'(sb[0].rd));
            chk("rnd reg_we", 64'(out_reg_we), 64'(sb[0].we));
            void'(sb.pop_front());
         end else begin
            chk("rnd reg_we idle", 64'(out_reg_we), 64'h0);
         end
         if (iv && exp_rdy) begin
            sb.push_back(e);
            n++;
         end
         @(posedge clk);
         #1;
         chk("rnd count", 64'(out_count), 64'(sb.size()));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
